// File: rtl/audio_echo_proc_pkg.sv
// Shared definitions for the audio echo processor.
//   - mode encodings for the mode input
//   - FSM state enumeration
//   - sat_add: signed add clamped to a w-bit two's-complement range
package audio_echo_proc_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_DELAY  = 2'b01;
  localparam logic [1:0] MODE_FIR    = 2'b10;
  localparam logic [1:0] MODE_IIR    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Operands are narrow samples sign-extended to 32 bits, so the raw sum
  // can never wrap before it is clamped.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        w
  );
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi)
      sat_add = hi;
    else if (s < lo)
      sat_add = lo;
    else
      sat_add = s;
  endfunction

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM used as the echo delay line.
//   clk    : clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable
//   raddr  : read address
//   rdata  : registered read data, valid the cycle after re
// No reset on the array or the read register so it maps onto block RAM.
module dp_ram_sync #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_echo_proc.sv
// Audio echo processor: bypass, pure delay, FIR echo or IIR echo on an
// offset-binary sample stream, using a circular delay buffer.
//   CLOCK_50    : system clock, rising edge
//   RST_N       : asynchronous active-low reset
//   data_in     : ADC sample, offset-binary
//   data_valid  : one-cycle strobe for a new sample
//   mode        : 00 bypass, 01 delay, 10 FIR echo, 11 IIR echo
//   delay       : echo delay in samples (0 treated as 1)
//   gain_sh     : echo term shifted right arithmetically by gain_sh+1
//   data_out    : processed sample, offset-binary, registered
//   out_valid   : one-cycle strobe when data_out updates
//   overrun     : sticky, a sample arrived while busy and was dropped
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for data_valid; latches sample and controls
// ST_READ  | issue RAM read at wr_ptr - D
// ST_CALC  | delayed word available; compute y and the word to store
// ST_WRITE | store word, advance wr_ptr/fill_cnt, present data_out
module audio_echo_proc
  import audio_echo_proc_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 13
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] delay,
  input  logic [1:0]        gain_sh,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              overrun
);

  localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_F    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t                   state;
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] y_q;
  logic signed [DATA_W-1:0] st_q;
  logic [1:0]               mode_q;
  logic [1:0]               gain_q;
  logic [ADDR_W-1:0]        dly_q;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W:0]          fill_cnt;

  logic [ADDR_W-1:0]        d_eff;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_raw;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] d_word;
  logic signed [DATA_W-1:0] echo;
  logic signed [DATA_W-1:0] y_c;
  logic signed [31:0]       sum32;
  logic                     unused_sum;
  logic                     ram_we;
  logic                     ram_re;

  assign d_eff   = (dly_q == '0) ? ONE_A : dly_q;
  assign rd_addr = wr_ptr - d_eff;
  assign ram_re  = (state == ST_READ);
  assign ram_we  = (state == ST_WRITE);
  assign rd_data = $signed(rd_raw);

  // Words older than the number of samples written since reset are stale
  // RAM contents and read as silence.
  assign d_word = (fill_cnt < {1'b0, d_eff}) ? '0 : rd_data;
  assign echo   = d_word >>> ({1'b0, gain_q} + 3'd1);

  assign sum32 = sat_add($signed({{(32-DATA_W){x_q[DATA_W-1]}}, x_q}),
                         $signed({{(32-DATA_W){echo[DATA_W-1]}}, echo}),
                         DATA_W);
  assign unused_sum = ^sum32[31:DATA_W];

  always_comb begin
    y_c = x_q;
    case (mode_q)
      MODE_BYPASS: y_c = x_q;
      MODE_DELAY:  y_c = d_word;
      default:     y_c = sum32[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      data_out  <= MID;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      st_q      <= '0;
      mode_q    <= MODE_BYPASS;
      gain_q    <= '0;
      dly_q     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (data_valid && (state != ST_IDLE))
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (data_valid) begin
            // offset-binary to two's complement is an MSB flip
            x_q    <= $signed({~data_in[DATA_W-1], data_in[DATA_W-2:0]});
            mode_q <= mode;
            dly_q  <= delay;
            gain_q <= gain_sh;
            state  <= ST_READ;
          end
        end
        ST_READ: state <= ST_CALC;
        ST_CALC: begin
          y_q   <= y_c;
          // only the IIR mode feeds its output back into the delay line
          st_q  <= (mode_q == MODE_IIR) ? y_c : x_q;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          wr_ptr <= wr_ptr + ONE_A;
          if (fill_cnt != FILL_MAX)
            fill_cnt <= fill_cnt + ONE_F;
          data_out  <= {~y_q[DATA_W-1], y_q[DATA_W-2:0]};
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dp_ram_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (st_q),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (rd_raw)
  );

endmodule

// File: tb/tb_audio_echo_proc.sv
// Scoreboard bench for audio_echo_proc: the driver pushes expected outputs
// (from a sample-history reference model) and a monitor pops on out_valid.
module tb_audio_echo_proc;

  localparam int DW = 10;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] delay = '0;
  logic [1:0]    gain_sh = '0;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t expq[$];
  int   hist[$];   // word stored for each sample since the last reset

  audio_echo_proc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLOCK_50   (clk),
    .RST_N      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .mode       (mode),
    .delay      (delay),
    .gain_sh    (gain_sh),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: y from x and the word stored D samples ago (0 if none yet).
  function automatic int model(input int din, input int m, input int dly, input int g);
    int x, dd, n, d, e, y, s;
    x  = din - 512;
    dd = (dly == 0) ? 1 : dly;
    n  = hist.size();
    d  = (n >= dd) ? hist[n - dd] : 0;
    e  = d >>> (g + 1);
    if (m == 0) y = x;
    else if (m == 1) y = d;
    else begin
      s = x + e;
      y = (s > 511) ? 511 : ((s < -512) ? -512 : s);
    end
    hist.push_back((m == 3) ? y : x);
    return y + 512;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=%0d required=none", data_out);
      end else begin
        e = expq.pop_front();
        chk("data_out", int'(data_out), e.val);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic scramble();
    data_in = DW'($urandom);
    mode    = 2'($urandom);
    delay   = AW'($urandom);
    gain_sh = 2'($urandom);
  endtask

  // force_exp >= 0 replaces the model's value with a hand-derived one.
  task automatic send(input int din, input int m, input int dly, input int g, input int force_exp);
    int ev;
    @(negedge clk);
    data_in    = DW'(din);
    mode       = 2'(m);
    delay      = AW'(dly);
    gain_sh    = 2'(g);
    data_valid = 1'b1;
    ev = model(din, m, dly, g);
    if (force_exp >= 0) ev = force_exp;
    expq.push_back('{ev, cyc + 4});
    @(negedge clk);
    data_valid = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", expq.size(), 0);
    expq.delete();
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("rst_data_out", int'(data_out), 512);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
  endtask

  initial begin
    int din;
    int vals030[6]   = '{600, 610, 620, 630, 640, 650};
    int exp030[6]    = '{512, 512, 512, 512, 600, 610};
    int exp032[7]    = '{612, 512, 562, 512, 537, 512, 524};

    repeat (3) @(negedge clk);
    chk("init_data_out", int'(data_out), 512);
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // bypass
    send(612, 0, 0, 0, 612);

    // pure delay fill
    do_reset();
    for (int i = 0; i < 6; i++) send(vals030[i], 1, 4, 0, exp030[i]);

    // FIR echo saturating
    do_reset();
    send(1000, 2, 1, 0, 1000);
    for (int i = 0; i < 3; i++) send(1000, 2, 1, 0, 1023);

    // IIR decay
    do_reset();
    for (int i = 0; i < 7; i++) send((i == 0) ? 612 : 512, 3, 2, 0, exp032[i]);

    // overrun: data_valid held for two consecutive samples
    do_reset();
    @(negedge clk);
    data_in = DW'(700); mode = 2'd0; delay = '0; gain_sh = '0;
    data_valid = 1'b1;
    expq.push_back('{model(700, 0, 0, 0), cyc + 4});
    repeat (2) @(negedge clk);
    data_valid = 1'b0;
    repeat (6) @(negedge clk);
    drain();
    chk("overrun_set", int'(overrun), 1);

    // reset while the sample is in CALC
    do_reset();
    @(negedge clk);
    data_in = DW'(800); mode = 2'd0; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_data_out", int'(data_out), 512);
    chk("abort_overrun", int'(overrun), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    repeat (8) @(negedge clk);

    // after the abort the buffer history must look empty
    send(900, 1, 1, 0, 512);
    send(300, 1, 1, 0, 900);

    // wrap-around with maximum delay
    do_reset();
    for (int i = 0; i < 8200; i++) begin
      din = $urandom_range(0, 1023);
      send(din, 1, 8191, 0, -1);
    end

    // randomized mixed modes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      din = $urandom_range(0, 1023);
      send(din, $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8191) : $urandom_range(0, 12),
           $urandom_range(0, 3), -1);
    end
    drain();
    chk("no_overrun_at_max_rate", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_echo_proc.md
AUDIO_ECHO_PROC -- requirements
Module: audio_echo_proc

Interface
REQ-001 Parameter DATA_W, default 10, sample width in offset-binary (mid-scale = 2^(DATA_W-1)) for both input and output.
REQ-002 Parameter ADDR_W, default 13, delay-buffer address width; buffer depth = 2^ADDR_W samples.
REQ-003 Port CLOCK_50  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 Port RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 Port data_in  in  DATA_W  ADC sample, offset-binary.
REQ-006 Port data_valid  in  1  one-cycle strobe marking data_in as a new sample.
REQ-007 Port mode  in  2  00 bypass, 01 pure delay, 10 FIR echo, 11 IIR echo.
REQ-008 Port delay  in  ADDR_W  echo delay in samples.
REQ-009 Port gain_sh  in  2  echo attenuation; the echo term is shifted right arithmetically by gain_sh+1.
REQ-010 Port data_out  out  DATA_W  processed sample, offset-binary, registered.
REQ-011 Port out_valid  out  1  one-cycle strobe when data_out updates.
REQ-012 Port overrun  out  1  sticky flag: a data_valid arrived while the block was busy.

Function
REQ-013 The block SHALL run an FSM IDLE -> READ -> CALC -> WRITE -> IDLE; it leaves IDLE only when data_valid=1.
REQ-014 In IDLE, on data_valid, it SHALL latch data_in, mode, delay and gain_sh; later changes to these inputs SHALL NOT affect the sample in flight.
REQ-015 Input conversion: x = data_in - 2^(DATA_W-1), as signed DATA_W bits.
REQ-016 Effective delay: D = max(delay, 1).
REQ-017 READ SHALL issue a synchronous RAM read at address (wr_ptr - D) mod 2^ADDR_W; the read data is valid in CALC.
REQ-018 If fill_cnt < D, the delayed word SHALL be treated as 0.
    - fill_cnt counts written samples and saturates at 2^ADDR_W.
REQ-019 Result in CALC, with d = delayed word:
    - mode 00: y = x.
    - mode 01: y = d.
    - mode 10 and 11: y = x + (d >>> (gain_sh+1)).
    - The sum is computed in DATA_W+1 bits and saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 WRITE SHALL store the word at wr_ptr, then increment wr_ptr modulo 2^ADDR_W (wrap-around), then increment fill_cnt.
    - The stored word is y in mode 11 and x in all other modes.
REQ-021 In WRITE, data_out SHALL be loaded with y + 2^(DATA_W-1) and out_valid SHALL pulse for exactly one cycle.
    - Latency: data_valid at cycle t gives out_valid at cycle t+3.
REQ-022 A data_valid seen in READ, CALC or WRITE SHALL be dropped and SHALL set overrun to 1; overrun clears only on reset.
REQ-023 Mode 00 SHALL still write the buffer, so that switching modes has history available.

Reset
REQ-024 When RST_N=0, asynchronously:
    - FSM goes to IDLE.
    - data_out = 2^(DATA_W-1) (mid-scale).
    - out_valid = 0, overrun = 0, wr_ptr = 0, fill_cnt = 0.
    - RAM contents are not cleared; REQ-018 masks stale data.
REQ-025 Reset asserted mid-operation SHALL abort the sample in flight with no RAM write and no out_valid pulse.

Structure
REQ-026 A shared package SHALL hold the mode encodings, the FSM state enum, and the saturating-add function.
REQ-027 The delay buffer SHALL be a sub-module, dp_ram_sync: one write port, one registered read port, DATA_W x 2^ADDR_W, inferable as block RAM.
REQ-028 The rest of the design SHALL be one FSM plus a datapath, roughly 150-300 lines.

Verification (DATA_W=10, ADDR_W=13)
REQ-029 Bypass: mode=00, data_in=612 -> data_out=612 with out_valid exactly 3 cycles after data_valid.
REQ-030 Delay fill: mode=01, delay=4, samples 600,610,620,630,640,650 -> outputs 512,512,512,512,600,610.
REQ-031 FIR echo with saturation:
    - mode=10, gain_sh=0, delay=1, constant input 1000 (x=488).
    - Output 1000 first, then 488+244=732, which saturates to 511 -> data_out=1023.
REQ-032 IIR echo decay:
    - mode=11, gain_sh=0, delay=2, one impulse 612 then inputs of 512.
    - Outputs 612,512,562,512,537,512,524,... (echo halves every 2 samples).
REQ-033 Overrun and reset:
    - A second data_valid 1 cycle after the first -> overrun=1 and exactly one out_valid.
    - RST_N low during CALC -> no out_valid, data_out=512, overrun=0.
REQ-034 Wrap: delay=8191 for 8200 samples -> the output at sample n equals the input at sample n-8191 across the wr_ptr wrap.
